// File: rtl/ps2_cmd_scheduler.sv
// PS/2 keyboard command scheduler: arbitrates LED and host command requests and
// sends each byte with a request-to-send hold, retrying on RESEND or timeout.
// Latency: RTS_CYCLES enabled cycles of clock hold per byte; backpressure: waits on tx_ready and rx_busy.
//
// Ports:
//   clk, _reset              bus clock, asynchronous active-low reset
//   clk7_en                  clock enable; every state change is qualified by it
//   req_led / led_state      requester 0: LED update {caps, num, scroll}
//   req_host / host_cmd /    requester 1: host command with an optional argument byte
//   host_has_arg / host_arg
//   rx_busy, rx_valid,       keyboard receiver status and received byte strobe
//   rx_byte
//   tx_ready, tx_load,       send shifter handshake and byte to transmit
//   tx_byte
//   ps2clk_hold              pull the PS/2 clock low before each byte
//   gnt, done, err, busy     one-hot grant, completion/abort strobes, FSM active
//
// Build option: define PS2_CMD_RESEND_EN to retry a byte up to MAX_RETRY times
// after 0xFE or timeout; without it the first failure aborts the transaction.
module ps2_cmd_scheduler #(
    parameter int RTS_CYCLES  = 710,
    parameter int ACK_TIMEOUT = 32767,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       clk7_en,
    input  logic       req_led,
    input  logic [2:0] led_state,
    input  logic       req_host,
    input  logic [7:0] host_cmd,
    input  logic       host_has_arg,
    input  logic [7:0] host_arg,
    input  logic       rx_busy,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       tx_load,
    output logic [7:0] tx_byte,
    output logic       ps2clk_hold,
    output logic [1:0] gnt,
    output logic       done,
    output logic       err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, ARB, RTS, SEND, WAIT_ACK, NEXT, FIN, FAIL
    } state_t;

    localparam logic [7:0]  KBD_ACK    = 8'hFA;
    localparam logic [7:0]  KBD_RESEND = 8'hFE;
    localparam logic [7:0]  SET_LEDS   = 8'hED;
    localparam logic [15:0] RTS_LAST   = 16'(RTS_CYCLES - 1);
    localparam logic [15:0] ACK_LIMIT  = 16'(ACK_TIMEOUT);

`ifdef PS2_CMD_RESEND_EN
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY);
`else
    // Resends disabled: the retry limit is zero, so any failure is final and
    // MAX_RETRY has no effect.
    localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRY) & 8'h00;
`endif

    state_t      state;
    logic [15:0] rts_cnt;
    logic [15:0] to_cnt;
    logic [7:0]  retry_cnt;
    logic [7:0]  byte0;
    logic [7:0]  byte1;
    logic        has_second;
    logic        byte_idx;
    logic        last_served;   // 0: LED served last, 1: host served last
    logic [7:0]  cur_byte;
    logic        ack_fail;

    assign cur_byte = byte_idx ? byte1 : byte0;
    assign busy     = (state != IDLE);

    // A received byte always wins over a timeout in the same cycle.
    assign ack_fail = rx_valid ? (rx_byte == KBD_RESEND) : (to_cnt >= ACK_LIMIT);

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state       <= IDLE;
            rts_cnt     <= 16'd0;
            to_cnt      <= 16'd0;
            retry_cnt   <= 8'd0;
            byte0       <= 8'd0;
            byte1       <= 8'd0;
            has_second  <= 1'b0;
            byte_idx    <= 1'b0;
            last_served <= 1'b1;
            tx_load     <= 1'b0;
            tx_byte     <= 8'd0;
            ps2clk_hold <= 1'b0;
            gnt         <= 2'b00;
            done        <= 1'b0;
            err         <= 1'b0;
        end else if (clk7_en) begin
            // Strobes last exactly one enabled cycle.
            tx_load <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if ((req_led || req_host) && !rx_busy) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    // LED wins when alone, or on a tie when the host went last.
                    if (req_led && (!req_host || last_served)) begin
                        gnt        <= 2'b01;
                        byte0      <= SET_LEDS;
                        byte1      <= {5'b00000, led_state};
                        has_second <= 1'b1;
                    end else if (req_host) begin
                        gnt        <= 2'b10;
                        byte0      <= host_cmd;
                        byte1      <= host_arg;
                        has_second <= host_has_arg;
                    end
                    if (req_led || req_host) begin
                        state       <= RTS;
                        ps2clk_hold <= 1'b1;
                        rts_cnt     <= 16'd0;
                        retry_cnt   <= 8'd0;
                        byte_idx    <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RTS: begin
                    // Hold was raised on entry; it drops on the RTS_CYCLES-th enabled cycle.
                    if (rts_cnt >= RTS_LAST) begin
                        ps2clk_hold <= 1'b0;
                        tx_load     <= 1'b1;
                        tx_byte     <= cur_byte;
                        state       <= SEND;
                    end else if (rts_cnt != 16'hFFFF) begin
                        rts_cnt <= rts_cnt + 16'd1;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        to_cnt <= 16'd0;
                        state  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (rx_valid && (rx_byte == KBD_ACK)) begin
                        state <= NEXT;
                    end else if (ack_fail) begin
                        if (retry_cnt >= RETRY_LIMIT) begin
                            err   <= 1'b1;
                            state <= FAIL;
                        end else begin
                            retry_cnt   <= retry_cnt + 8'd1;
                            ps2clk_hold <= 1'b1;
                            rts_cnt     <= 16'd0;
                            state       <= RTS;
                        end
                    end else if (to_cnt != 16'hFFFF) begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                NEXT: begin
                    retry_cnt <= 8'd0;
                    if (!byte_idx && has_second) begin
                        byte_idx    <= 1'b1;
                        ps2clk_hold <= 1'b1;
                        rts_cnt     <= 16'd0;
                        state       <= RTS;
                    end else begin
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN, FAIL: begin
                    last_served <= gnt[1];
                    gnt         <= 2'b00;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Directed bench for ps2_cmd_scheduler with a keyboard/shifter responder model.
// Latency: checks RTS_CYCLES hold per byte; responder returns scripted bytes after each tx_load.
// Backpressure: tx_ready is dropped for a few cycles after every load; rx_busy gates the start.
`timescale 1ns/1ps
module tb_ps2_cmd_scheduler;

    localparam int RTS_N  = 710;
    localparam int ACK_TO = 200;
    localparam int NONE   = -1;

    logic       clk = 1'b0;
    logic       _reset = 1'b0;
    logic       clk7_en = 1'b1;
    logic       req_led = 1'b0;
    logic [2:0] led_state = 3'd0;
    logic       req_host = 1'b0;
    logic [7:0] host_cmd = 8'd0;
    logic       host_has_arg = 1'b0;
    logic [7:0] host_arg = 8'd0;
    logic       rx_busy = 1'b0;
    logic       tx_ready = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       tx_load;
    logic [7:0] tx_byte;
    logic       ps2clk_hold;
    logic [1:0] gnt;
    logic       done;
    logic       err;
    logic       busy;

    ps2_cmd_scheduler #(
        .RTS_CYCLES (RTS_N),
        .ACK_TIMEOUT(ACK_TO),
        .MAX_RETRY  (3)
    ) dut (
        .clk         (clk),
        ._reset      (_reset),
        .clk7_en     (clk7_en),
        .req_led     (req_led),
        .led_state   (led_state),
        .req_host    (req_host),
        .host_cmd    (host_cmd),
        .host_has_arg(host_has_arg),
        .host_arg    (host_arg),
        .rx_busy     (rx_busy),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .tx_load     (tx_load),
        .tx_byte     (tx_byte),
        .ps2clk_hold (ps2clk_hold),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] tx_q[$];
    logic [1:0] gnt_q[$];
    int         hold_q[$];
    int         resp_q[$];   // NONE: silence; >255: junk 0xAA first, then low byte

    int   hold_run = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    logic tx_load_q = 1'b0;
    logic done_q = 1'b0;
    logic err_q = 1'b0;
    int   rs_phase = 0;
    int   rs_cnt = 0;
    int   rs_resp = 0;
    bit   en_half = 1'b0;
    logic [1:0] end_gnt = 2'b00;

    // Enable generator, monitor and keyboard/shifter responder, all on the falling edge.
    always @(negedge clk) begin
        clk7_en  = en_half ? !clk7_en : 1'b1;
        rx_valid = 1'b0;
        if (!_reset) begin
            hold_run  = 0;
            rs_phase  = 0;
            tx_ready  = 1'b1;
            tx_load_q = 1'b0;
            done_q    = 1'b0;
            err_q     = 1'b0;
        end else begin
            if (tx_load && !tx_load_q) begin
                tx_q.push_back(tx_byte);
                gnt_q.push_back(gnt);
                hold_q.push_back(hold_run);
                hold_run = 0;
                rs_resp  = (resp_q.size() > 0) ? resp_q.pop_front() : NONE;
                tx_ready = 1'b0;
                rs_cnt   = 5;
                rs_phase = 1;
            end else begin
                case (rs_phase)
                    1: begin
                        if (rs_cnt > 0) rs_cnt--;
                        else begin
                            tx_ready = 1'b1;
                            rs_cnt   = 4;
                            rs_phase = 2;
                        end
                    end
                    2: begin
                        if (clk7_en) begin
                            if (rs_cnt > 0) rs_cnt--;
                            else if (rs_resp == NONE) rs_phase = 0;
                            else begin
                                rx_valid = 1'b1;
                                if (rs_resp > 255) begin
                                    rx_byte = 8'hAA;
                                    rs_resp = rs_resp & 255;
                                    rs_cnt  = 3;
                                end else begin
                                    rx_byte  = rs_resp[7:0];
                                    rs_phase = 0;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (ps2clk_hold && clk7_en) hold_run++;
            if (done && !done_q) done_cnt++;
            if (err && !err_q) err_cnt++;
            tx_load_q = tx_load;
            done_q    = done;
            err_q     = err;
        end
    end

    function automatic logic [39:0] packed_tx();
        logic [39:0] v;
        v = 40'd0;
        v[39:32] = 8'(tx_q.size());
        foreach (tx_q[i]) if (i < 4) v[31:0] = {v[23:0], tx_q[i]};
        return v;
    endfunction

    function automatic logic [23:0] packed_gnt();
        logic [23:0] v;
        v = 24'd0;
        v[23:16] = 8'(gnt_q.size());
        foreach (gnt_q[i]) if (i < 8) v[15:0] = {v[13:0], gnt_q[i]};
        return v;
    endfunction

    function automatic int bad_holds();
        int n;
        n = 0;
        foreach (hold_q[i]) if (hold_q[i] != RTS_N) n++;
        return n;
    endfunction

    task automatic clear_logs();
        tx_q.delete();
        gnt_q.delete();
        hold_q.delete();
        resp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        _reset = 1'b0;
        repeat (3) @(negedge clk);
        _reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_txn(input int budget, input string name);
        bit seen;
        seen = 1'b0;
        checks++;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done || err) begin
                seen    = 1'b1;
                end_gnt = gnt;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s_wait: no done/err within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        _reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, busy, ps2clk_hold, tx_load, done, err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000000", {gnt, busy, ps2clk_hold, tx_load, done, err});
        end
        _reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, busy, ps2clk_hold} !== 4'd0) begin
            errors++;
            $display("FAIL reset_idle got %b want 0000", {gnt, busy, ps2clk_hold});
        end
    endtask

    task automatic test_led();
        int d0, e0;
        clear_logs();
        resp_q.push_back(256 + 8'hFA);   // junk byte is ignored before the ACK
        resp_q.push_back(8'hFA);
        d0 = done_cnt;
        e0 = err_cnt;
        led_state = 3'b101;
        req_led = 1'b1;
        for (int i = 0; i < 20 && gnt == 2'b00; i++) @(negedge clk);
        req_led = 1'b0;                  // dropping the request must not abort
        wait_txn(5000, "led");
        repeat (4) @(negedge clk);
        checks++;
        if (packed_tx() !== 40'h020000ED05) begin
            errors++; $display("FAIL led_tx got %h want 020000ed05", packed_tx());
        end
        checks++;
        if (packed_gnt() !== 24'h020005) begin
            errors++; $display("FAIL led_gnt got %h want 020005", packed_gnt());
        end
        checks++;
        if (bad_holds() != 0) begin
            errors++; $display("FAIL led_hold got %0d bad hold lengths want 0", bad_holds());
        end
        checks++;
        if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0) begin
            errors++; $display("FAIL led_done got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
        checks++;
        if (end_gnt !== 2'b01 || busy !== 1'b0) begin
            errors++; $display("FAIL led_end got gnt=%b busy=%b want 01 0", end_gnt, busy);
        end
    endtask

    task automatic test_both();
        do_reset();
        clear_logs();
        repeat (3) resp_q.push_back(8'hFA);
        led_state = 3'b010;
        host_cmd = 8'hF4;
        host_has_arg = 1'b0;
        req_led = 1'b1;
        req_host = 1'b1;
        wait_txn(5000, "both_first");
        req_led = 1'b0;
        checks++;
        if (end_gnt !== 2'b01) begin
            errors++; $display("FAIL both_first_gnt got %b want 01", end_gnt);
        end
        wait_txn(5000, "both_second");
        req_host = 1'b0;
        checks++;
        if (end_gnt !== 2'b10) begin
            errors++; $display("FAIL both_second_gnt got %b want 10", end_gnt);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (packed_tx() !== 40'h0300ED02F4) begin
            errors++; $display("FAIL both_tx got %h want 0300ed02f4", packed_tx());
        end
        checks++;
        if (packed_gnt() !== 24'h030016) begin
            errors++; $display("FAIL both_gnt got %h want 030016", packed_gnt());
        end
    endtask

    task automatic test_clk_en();
        clear_logs();
        resp_q.push_back(8'hFA);
        resp_q.push_back(8'hFA);
        en_half = 1'b1;
        led_state = 3'b011;
        req_led = 1'b1;
        wait_txn(9000, "clk_en");
        req_led = 1'b0;
        repeat (6) @(negedge clk);
        en_half = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (packed_tx() !== 40'h020000ED03) begin
            errors++; $display("FAIL clk_en_tx got %h want 020000ed03", packed_tx());
        end
        checks++;
        if (bad_holds() != 0 || hold_q.size() != 2) begin
            errors++; $display("FAIL clk_en_hold got %0d bad of %0d want 0 of 2", bad_holds(), hold_q.size());
        end
    endtask

    task automatic test_resend();
        int d0, e0;
        clear_logs();
        resp_q.push_back(8'hFE);
        resp_q.push_back(8'hFA);
        resp_q.push_back(8'hFA);
        d0 = done_cnt;
        e0 = err_cnt;
        host_cmd = 8'hF3;
        host_arg = 8'h20;
        host_has_arg = 1'b1;
        req_host = 1'b1;
        wait_txn(8000, "resend");
        req_host = 1'b0;
        repeat (4) @(negedge clk);
`ifdef PS2_CMD_RESEND_EN
        checks++;
        if (packed_tx() !== 40'h0300F3F320) begin
            errors++; $display("FAIL resend_tx got %h want 0300f3f320", packed_tx());
        end
        checks++;
        if ((done_cnt - d0) != 1 || (err_cnt - e0) != 0) begin
            errors++; $display("FAIL resend_done got done=%0d err=%0d want 1 0", done_cnt - d0, err_cnt - e0);
        end
`else
        checks++;
        if (packed_tx() !== 40'h01000000F3) begin
            errors++; $display("FAIL resend_tx got %h want 01000000f3", packed_tx());
        end
        checks++;
        if ((done_cnt - d0) != 0 || (err_cnt - e0) != 1) begin
            errors++; $display("FAIL resend_done got done=%0d err=%0d want 0 1", done_cnt - d0, err_cnt - e0);
        end
`endif
    endtask

    task automatic test_timeout();
        int d0, e0;
        clear_logs();
        d0 = done_cnt;
        e0 = err_cnt;
        host_cmd = 8'hFF;
        host_has_arg = 1'b0;
        req_host = 1'b1;
        wait_txn(8000, "timeout");
        req_host = 1'b0;
        repeat (4) @(negedge clk);
`ifdef PS2_CMD_RESEND_EN
        checks++;
        if (packed_tx() !== 40'h04FFFFFFFF) begin
            errors++; $display("FAIL timeout_tx got %h want 04ffffffff", packed_tx());
        end
        checks++;
        if (packed_gnt() !== 24'h0400AA) begin
            errors++; $display("FAIL timeout_gnt got %h want 0400aa", packed_gnt());
        end
`else
        checks++;
        if (packed_tx() !== 40'h01000000FF) begin
            errors++; $display("FAIL timeout_tx got %h want 01000000ff", packed_tx());
        end
        checks++;
        if (packed_gnt() !== 24'h010002) begin
            errors++; $display("FAIL timeout_gnt got %h want 010002", packed_gnt());
        end
`endif
        checks++;
        if (bad_holds() != 0) begin
            errors++; $display("FAIL timeout_hold got %0d bad hold lengths want 0", bad_holds());
        end
        checks++;
        if ((err_cnt - e0) != 1 || (done_cnt - d0) != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_err got err=%0d done=%0d busy=%b want 1 0 0", err_cnt - e0, done_cnt - d0, busy);
        end
    endtask

    task automatic test_rx_busy();
        int d0;
        clear_logs();
        resp_q.push_back(8'hFA);
        d0 = done_cnt;
        rx_busy = 1'b1;
        host_cmd = 8'hF4;
        host_has_arg = 1'b0;
        req_host = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (tx_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rx_busy_hold got tx=%0d busy=%b want 0 0", tx_q.size(), busy);
        end
        rx_busy = 1'b0;
        wait_txn(5000, "rx_busy");
        req_host = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (packed_tx() !== 40'h01000000F4 || (done_cnt - d0) != 1) begin
            errors++; $display("FAIL rx_busy_tx got %h done=%0d want 01000000f4 1", packed_tx(), done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        clear_logs();
        host_cmd = 8'hF4;
        host_has_arg = 1'b0;
        req_host = 1'b1;
        for (int i = 0; i < 3000 && tx_q.size() == 0; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ps2clk_hold !== 1'b0 || tx_q.size() != 1) begin
            errors++;
            $display("FAIL mid_wait_ack got busy=%b hold=%b tx=%0d want 1 0 1", busy, ps2clk_hold, tx_q.size());
        end
        d0 = done_cnt;
        e0 = err_cnt;
        _reset = 1'b0;
        req_host = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, busy, ps2clk_hold, tx_load, done, err} !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs got %b want 0000000", {gnt, busy, ps2clk_hold, tx_load, done, err});
        end
        _reset = 1'b1;
        repeat (400) @(negedge clk);
        checks++;
        if ((done_cnt - d0) != 0 || (err_cnt - e0) != 0 || busy !== 1'b0 || tx_q.size() != 1) begin
            errors++;
            $display("FAIL mid_reset_after got done=%0d err=%0d busy=%b tx=%0d want 0 0 0 1",
                     done_cnt - d0, err_cnt - e0, busy, tx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_both();
        test_clk_en();
        test_resend();
        test_timeout();
        test_rx_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
